// File: rtl/aes_blk_packer.sv
// aes_blk_packer: packs a 32-bit inbound word stream into 128-bit AES blocks tagged with tlast.
// Ports: clk/resetn (async, active-low); s_axis_tdata/tvalid/tlast/tready inbound words;
//        blk_tdata {tlast, block}/blk_tvalid/blk_tready outbound blocks; pad_err sticky
//        short-packet flag; blk_count blocks delivered since reset (wraps at 16 bits).

// Generic shift-style FIFO: head entry is always mem_q[0], so the output is a plain register.
// Latency: a pushed entry is visible on out_dat/out_vld the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; count exposed for the caller.
module aes_blk_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    wr_idx;
    logic             vld_q;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = vld_q && out_rdy;
    assign do_push = in_vld && ((count_q < CW'(DEPTH)) || do_pop);
    // With a simultaneous pop the entries shift down first, so the new entry lands one slot lower.
    assign wr_idx  = count_q - CW'(do_pop);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (wr_idx == CW'(i))) begin
                mem_d[i] = in_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            vld_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            vld_q   <= (count_d != '0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_vld = vld_q;
    assign out_dat = mem_q[0];
    assign count   = count_q;

endmodule

// Word-to-block packer: four words (or fewer, ended by tlast) form one zero-padded block.
// Latency: blk_tvalid rises the cycle after the completing word is accepted; 1 word/cycle sustained.
// Backpressure: a completing word stalls only while the 2-entry output FIFO is full (registered occupancy).
module aes_blk_packer #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BLK_WIDTH      = 128
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [BUS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [BLK_WIDTH:0]        blk_tdata,
    output logic                      blk_tvalid,
    input  logic                      blk_tready,
    output logic                      pad_err,
    output logic [15:0]               blk_count
);

    localparam int NLANE = BLK_WIDTH / BUS_DATA_WIDTH;
    localparam int FDEPTH = 2;
    localparam int FCW    = $clog2(FDEPTH + 1);

    typedef enum logic [1:0] {FILL0, FILL1, FILL2, FILL3} fill_e;

    fill_e                     state_q;
    fill_e                     state_d;
    logic [1:0]                lane_idx;
    logic [BUS_DATA_WIDTH-1:0] lane_q [NLANE];
    logic [BLK_WIDTH-1:0]      blk_asm;
    logic                      run_q;
    logic                      last_lane;
    logic                      completes;
    logic                      word_acc;
    logic                      blk_push;
    logic                      blk_pop;
    logic [FCW-1:0]            fifo_count;
    logic                      pad_err_q;
    logic [15:0]               blk_count_q;

    // State register: current fill lane.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= FILL0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance one lane per accepted word, return to FILL0 when a block completes.
    always_comb begin
        state_d = state_q;
        if (word_acc) begin
            if (completes) begin
                state_d = FILL0;
            end else begin
                case (state_q)
                    FILL0:   state_d = FILL1;
                    FILL1:   state_d = FILL2;
                    FILL2:   state_d = FILL3;
                    default: state_d = FILL0;
                endcase
            end
        end
    end

    // Outputs of the fill FSM. run_q keeps tready low until the first edge after reset release.
    // Only completing words look at FIFO occupancy, and occupancy is a register, so blk_tready
    // never reaches s_axis_tready combinationally.
    always_comb begin
        lane_idx      = state_q;
        last_lane     = (state_q == FILL3);
        completes     = last_lane || s_axis_tlast;
        s_axis_tready = run_q && (!completes || (fifo_count < FCW'(FDEPTH)));
    end

    assign word_acc = s_axis_tvalid && s_axis_tready;
    assign blk_push = word_acc && completes;
    assign blk_pop  = blk_tvalid && blk_tready;

    // Lanes above the current one are always zero (cleared on every push), which gives the padding.
    always_comb begin
        blk_asm = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (lane_idx == 2'(i)) begin
                blk_asm[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = s_axis_tdata;
            end else begin
                blk_asm[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = lane_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q       <= 1'b0;
            pad_err_q   <= 1'b0;
            blk_count_q <= '0;
            for (int i = 0; i < NLANE; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            run_q <= 1'b1;
            if (word_acc) begin
                if (completes) begin
                    for (int i = 0; i < NLANE; i++) begin
                        lane_q[i] <= '0;
                    end
                    if (!last_lane) begin
                        pad_err_q <= 1'b1;
                    end
                end else begin
                    lane_q[lane_idx] <= s_axis_tdata;
                end
            end
            if (blk_pop) begin
                blk_count_q <= blk_count_q + 16'd1;
            end
        end
    end

    aes_blk_fifo #(
        .WIDTH (BLK_WIDTH + 1),
        .DEPTH (FDEPTH),
        .CW    (FCW)
    ) u_out_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .in_vld  (blk_push),
        .in_dat  ({s_axis_tlast, blk_asm}),
        .out_vld (blk_tvalid),
        .out_dat (blk_tdata),
        .out_rdy (blk_tready),
        .count   (fifo_count)
    );

    assign pad_err   = pad_err_q;
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_aes_blk_packer.sv
// Testbench for aes_blk_packer: directed scenarios plus randomized traffic against a word-list model.
// Latency: n/a (bench); checks one-cycle block latency and 1 word/cycle throughput.
// Backpressure: drives random and held-low blk_tready; checks stalls, ordering and data hold.
module tb_aes_blk_packer;

    logic         clk = 1'b0;
    logic         resetn;
    logic [31:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [128:0] blk_tdata;
    logic         blk_tvalid;
    logic         blk_tready;
    logic         pad_err;
    logic [15:0]  blk_count;

    aes_blk_packer #(
        .BUS_DATA_WIDTH (32),
        .BLK_WIDTH      (128)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .blk_tdata     (blk_tdata),
        .blk_tvalid    (blk_tvalid),
        .blk_tready    (blk_tready),
        .pad_err       (pad_err),
        .blk_count     (blk_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    // Reference model: accepted words collect in cur; a block is formed on tlast or the 4th word.
    logic [31:0]  cur[$];
    logic [128:0] exp_q[$];
    logic [128:0] obs_q[$];
    int           obs_cyc[$];
    bit           m_pad = 1'b0;
    logic [15:0]  m_cnt = '0;
    int           stall_viol = 0;
    int           rdy_low = 0;
    int           tmo = 0;
    bit           hold_prev = 1'b0;
    logic [128:0] prev_dat = '0;
    logic [128:0] mblk;

    always @(negedge clk) begin
        if (!resetn) begin
            cur.delete();
            exp_q.delete();
            obs_q.delete();
            obs_cyc.delete();
            m_pad     = 1'b0;
            m_cnt     = '0;
            hold_prev = 1'b0;
        end else begin
            if (s_axis_tvalid && s_axis_tready) begin
                cur.push_back(s_axis_tdata);
                if (s_axis_tlast || cur.size() == 4) begin
                    mblk = '0;
                    for (int i = 0; i < cur.size(); i++) mblk[i*32 +: 32] = cur[i];
                    mblk[128] = s_axis_tlast;
                    if (s_axis_tlast && cur.size() < 4) m_pad = 1'b1;
                    exp_q.push_back(mblk);
                    cur.delete();
                end
            end
            if (hold_prev && (blk_tvalid !== 1'b1 || blk_tdata !== prev_dat)) stall_viol++;
            hold_prev = blk_tvalid && !blk_tready;
            prev_dat  = blk_tdata;
            if (blk_tvalid && blk_tready) begin
                obs_q.push_back(blk_tdata);
                obs_cyc.push_back(cyc);
                m_cnt = m_cnt + 16'd1;
            end
            if (s_axis_tvalid && !s_axis_tready) rdy_low++;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (s_axis_tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) tmo++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; blk_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (blk_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_blk_tvalid got %b want 0", blk_tvalid); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready got %b want 0", s_axis_tready); end
        n_cmp++; if (pad_err !== 1'b0) begin n_fail++; $display("FAIL rst_pad_err got %b want 0", pad_err); end
        n_cmp++; if (blk_count !== 16'h0000) begin n_fail++; $display("FAIL rst_blk_count got %h want 0000", blk_count); end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_tready got %b want 1", s_axis_tready); end
    endtask

    task automatic test_single_block;
        logic [128:0] got;
        logic [128:0] want;
        want = {1'b1, 128'h00000004_00000003_00000002_00000001};
        blk_tready = 1'b1; tmo = 0;
        send_word(32'h1, 1'b0); send_word(32'h2, 1'b0); send_word(32'h3, 1'b0);
        n_cmp++; if (blk_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_vld got %b want 0", blk_tvalid); end
        send_word(32'h4, 1'b1);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        n_cmp++; if (blk_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_latency blk_tvalid got %b want 1", blk_tvalid); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL single_nblk got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL single_data got %h want %h", got, want); end
        end
        n_cmp++; if (blk_count !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", blk_count); end
        n_cmp++; if (pad_err !== 1'b0) begin n_fail++; $display("FAIL single_pad got %b want 0", pad_err); end
        n_cmp++; if (tmo !== 0) begin n_fail++; $display("FAIL single_timeout got %0d want 0", tmo); end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_pad;
        logic [128:0] got;
        logic [128:0] want;
        want = {1'b1, 128'h00000000_00000000_0000000B_0000000A};
        blk_tready = 1'b1; tmo = 0;
        send_word(32'hA, 1'b0); send_word(32'hB, 1'b1);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL pad_nblk got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL pad_data got %h want %h", got, want); end
        end
        n_cmp++; if (pad_err !== 1'b1) begin n_fail++; $display("FAIL pad_err got %b want 1", pad_err); end
        n_cmp++; if (tmo !== 0) begin n_fail++; $display("FAIL pad_timeout got %0d want 0", tmo); end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure;
        logic [128:0] got;
        logic [128:0] want;
        logic [31:0]  w12;
        blk_tready = 1'b0; tmo = 0; stall_viol = 0;
        for (int i = 0; i < 11; i++) send_word($urandom, 1'b0);
        w12 = $urandom;
        s_axis_tdata = w12; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready_full got %b want 0", s_axis_tready); end
        n_cmp++; if (blk_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_vld_held got %b want 1", blk_tvalid); end
        n_cmp++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL bp_no_pop got %0d want 0", obs_q.size()); end
        @(posedge clk);
        #1;
        blk_tready = 1'b1;
        send_word(w12, 1'b0);
        s_axis_tvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (obs_q.size() !== 3 || exp_q.size() !== 3) begin n_fail++; $display("FAIL bp_nblk got %0d/%0d want 3", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL bp_order got %h want %h", got, want); end
        end
        n_cmp++; if (blk_count !== m_cnt) begin n_fail++; $display("FAIL bp_count got %0d want %0d", blk_count, m_cnt); end
        n_cmp++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_hold got %0d want 0", stall_viol); end
        n_cmp++; if (tmo !== 0) begin n_fail++; $display("FAIL bp_timeout got %0d want 0", tmo); end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [128:0] got;
        logic [128:0] want;
        int c0;
        int bad_gap;
        blk_tready = 1'b1; tmo = 0; rdy_low = 0; bad_gap = 0;
        c0 = cyc;
        for (int i = 0; i < 32; i++) send_word($urandom, (i % 4) == 3);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        n_cmp++; if (cyc - c0 !== 32) begin n_fail++; $display("FAIL b2b_cycles got %0d want 32", cyc - c0); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (rdy_low !== 0) begin n_fail++; $display("FAIL b2b_tready_drop got %0d want 0", rdy_low); end
        n_cmp++; if (obs_q.size() !== 8 || exp_q.size() !== 8) begin n_fail++; $display("FAIL b2b_nblk got %0d/%0d want 8", obs_q.size(), exp_q.size()); end
        for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] - obs_cyc[i-1] != 4) bad_gap++;
        n_cmp++; if (bad_gap !== 0) begin n_fail++; $display("FAIL b2b_spacing got %0d bad gaps want 0", bad_gap); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL b2b_data got %h want %h", got, want); end
        end
        n_cmp++; if (tmo !== 0) begin n_fail++; $display("FAIL b2b_timeout got %0d want 0", tmo); end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        logic [128:0] got;
        logic [128:0] want;
        bit done;
        done = 1'b0; tmo = 0; stall_viol = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        s_axis_tvalid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_word($urandom, $urandom_range(0, 5) == 0);
                end
                send_word($urandom, 1'b1);
                s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    blk_tready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        blk_tready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_nblk got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL rnd_data got %h want %h", got, want); end
        end
        n_cmp++; if (pad_err !== m_pad) begin n_fail++; $display("FAIL rnd_pad got %b want %b", pad_err, m_pad); end
        n_cmp++; if (blk_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", blk_count, m_cnt); end
        n_cmp++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rnd_hold got %0d want 0", stall_viol); end
        n_cmp++; if (tmo !== 0) begin n_fail++; $display("FAIL rnd_timeout got %0d want 0", tmo); end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [31:0]  w[4];
        logic [128:0] got;
        logic [128:0] want;
        blk_tready = 1'b1; tmo = 0;
        send_word($urandom, 1'b0); send_word($urandom, 1'b0);
        s_axis_tvalid = 1'b0;
        resetn = 1'b0;
        #2;
        n_cmp++; if (blk_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld got %b want 0", blk_tvalid); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tready got %b want 0", s_axis_tready); end
        n_cmp++; if (pad_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pad got %b want 0", pad_err); end
        n_cmp++; if (blk_count !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_count got %h want 0000", blk_count); end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            send_word(w[i], i == 3);
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        want = {1'b1, w[3], w[2], w[1], w[0]};
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL mid_nblk got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL mid_clean_block got %h want %h", got, want); end
        end
        n_cmp++; if (blk_count !== 16'd1) begin n_fail++; $display("FAIL mid_count got %0d want 1", blk_count); end
        n_cmp++; if (tmo !== 0) begin n_fail++; $display("FAIL mid_timeout got %0d want 0", tmo); end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_count_wrap;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        blk_tready = 1'b1; tmo = 0;
        for (int i = 0; i < 65537; i++) send_word($urandom, 1'b1);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (obs_q.size() !== 65537) begin n_fail++; $display("FAIL wrap_nblk got %0d want 65537", obs_q.size()); end
        n_cmp++; if (blk_count !== 16'h0001) begin n_fail++; $display("FAIL wrap_count got %h want 0001", blk_count); end
        n_cmp++; if (pad_err !== 1'b1) begin n_fail++; $display("FAIL wrap_pad got %b want 1", pad_err); end
        n_cmp++; if (tmo !== 0) begin n_fail++; $display("FAIL wrap_timeout got %0d want 0", tmo); end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_block();
        test_pad();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
